// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ controller.
// Holds the FSM state encoding, the word width and the instruction length.
package subleq_pkg;

    localparam int WORD_W    = 16;
    localparam int INSTR_LEN = 3;

    localparam logic [WORD_W-1:0] DEFAULT_HALT_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        WRITE_B,
        HALT
    } state_t;

endpackage

// File: rtl/subleq_alu.sv
// Combinational subtract-and-test unit.
// Computes mem[B] - mem[A] and flags a result that is less than or equal to zero.
module subleq_alu
    import subleq_pkg::*;
(
    input  logic [WORD_W-1:0] val_a,
    input  logic [WORD_W-1:0] val_b,
    output logic [WORD_W-1:0] diff,
    output logic              leq
);

    // Overflow is discarded; the sign test uses the truncated result.
    assign diff = val_b - val_a;
    assign leq  = diff[WORD_W-1] | (diff == '0);

endmodule

// File: rtl/subleq_control.sv
// Six-cycle-per-instruction SUBLEQ sequencer driving a single-port word memory.
// Memory outputs are decoded from the state and registers only, never from mem_rdata.
module subleq_control
    import subleq_pkg::*;
#(
    parameter logic [WORD_W-1:0] HALT_ADDR = DEFAULT_HALT_ADDR,
    parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic [WORD_W-1:0] instr_count
);

    state_t state, state_next;

    logic [WORD_W-1:0] a_reg, b_reg, c_reg;
    logic [WORD_W-1:0] val_a, val_b;
    logic [WORD_W-1:0] diff;
    logic              leq;
    logic              take_halt;

    subleq_alu u_alu (
        .val_a (val_a),
        .val_b (val_b),
        .diff  (diff),
        .leq   (leq)
    );

    assign take_halt = leq && (c_reg == HALT_ADDR);
    assign mem_wdata = diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_A;
        end else if (run) begin
            state <= state_next;
        end
    end

    // Strobes are suppressed while stalled or in reset so a held or interrupted access never commits.
    always_comb begin
        state_next = state;
        mem_addr   = pc;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            FETCH_A: begin
                mem_re     = 1'b1;
                mem_addr   = pc;
                state_next = FETCH_B;
            end
            FETCH_B: begin
                mem_re     = 1'b1;
                mem_addr   = pc + WORD_W'(1);
                state_next = FETCH_C;
            end
            FETCH_C: begin
                mem_re     = 1'b1;
                mem_addr   = pc + WORD_W'(2);
                state_next = READ_A;
            end
            READ_A: begin
                mem_re     = 1'b1;
                mem_addr   = a_reg;
                state_next = READ_B;
            end
            READ_B: begin
                mem_re     = 1'b1;
                mem_addr   = b_reg;
                state_next = WRITE_B;
            end
            WRITE_B: begin
                mem_we     = 1'b1;
                mem_addr   = b_reg;
                state_next = take_halt ? HALT : FETCH_A;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH_A;
            end
        endcase
        if (rst || !run) begin
            mem_re = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            halted      <= 1'b0;
            instr_count <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            val_a       <= '0;
            val_b       <= '0;
        end else if (run) begin
            unique case (state)
                FETCH_A: a_reg <= mem_rdata;
                FETCH_B: b_reg <= mem_rdata;
                FETCH_C: c_reg <= mem_rdata;
                READ_A:  val_a <= mem_rdata;
                READ_B:  val_b <= mem_rdata;
                WRITE_B: begin
                    pc          <= leq ? c_reg : pc + WORD_W'(INSTR_LEN);
                    instr_count <= instr_count + WORD_W'(1);
                    if (take_halt) begin
                        halted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
